subtractor_nnbit_ahead_multicycle: RTL and testbench

- Multi-cycle, nibble-serial subtractor that computes A − B − borrow_in.
- Processes 4 bits per clock through a single adder_04bit_ahead instance, fed with inverted B and an inverted borrow as carry.
- Trades latency (DATA_WIDTH/4 cycles) for area, and sits in the calc library beside the combinational adders.
- Uses a valid/ready handshake on both input and output so it can sit inside ALU datapaths with backpressure.

---
 rtl/calc_sub_pkg.sv | 25 ++
 rtl/adder_04bit_ahead.sv | 36 +++
 rtl/subtractor_nnbit_ahead_multicycle.sv | 150 +++++++++++++++
 tb/tb_subtractor_nnbit_ahead_multicycle.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/calc_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_sub_pkg
// Description : Shared types and helpers for the nibble-serial subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_sub_pkg;

  localparam int NIBBLE_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Nibble counter width: enough bits to count N nibbles, never less than one.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_04bit_ahead.sv
`default_nettype none
// ============================================================================
// Module      : adder_04bit_ahead
// Description : 4-bit carry-lookahead adder, combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_04bit_ahead (
  input  logic [3:0] i_num_a,
  input  logic [3:0] i_num_b,
  input  logic       i_cry,
  output logic [3:0] o_sum,
  output logic       o_cry
);

  logic [3:0] w_gen;
  logic [3:0] w_prp;
  logic [4:0] w_c;

  // Generate/propagate terms and flattened lookahead carries.
  always_comb begin
    w_gen  = i_num_a & i_num_b;
    w_prp  = i_num_a ^ i_num_b;
    w_c[0] = i_cry;
    w_c[1] = w_gen[0] | (w_prp[0] & i_cry);
    w_c[2] = w_gen[1] | (w_prp[1] & w_gen[0]) | (w_prp[1] & w_prp[0] & i_cry);
    w_c[3] = w_gen[2] | (w_prp[2] & w_gen[1]) | (w_prp[2] & w_prp[1] & w_gen[0])
           | (w_prp[2] & w_prp[1] & w_prp[0] & i_cry);
    w_c[4] = w_gen[3] | (w_prp[3] & w_gen[2]) | (w_prp[3] & w_prp[2] & w_gen[1])
           | (w_prp[3] & w_prp[2] & w_prp[1] & w_gen[0])
           | (w_prp[3] & w_prp[2] & w_prp[1] & w_prp[0] & i_cry);
    o_sum  = w_prp ^ w_c[3:0];
    o_cry  = w_c[4];
  end

endmodule
`default_nettype wire

// File: rtl/subtractor_nnbit_ahead_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : subtractor_nnbit_ahead_multicycle
// Description : Nibble-serial A - B - borrow using one 4-bit lookahead adder
//               (A + ~B + ~borrow), valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module subtractor_nnbit_ahead_multicycle
  import calc_sub_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_num_a,
  input  logic [DATA_WIDTH-1:0] i_num_b,
  input  logic                  i_brw,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_res,
  output logic                  o_brw,
  output logic                  o_ovf
);

  localparam int                NUM_NIB = DATA_WIDTH / NIBBLE_WIDTH;
  localparam int                CNT_W   = cnt_width(NUM_NIB);
  localparam logic [CNT_W-1:0]  C_LAST  = CNT_W'(NUM_NIB - 1);

  if ((DATA_WIDTH % NIBBLE_WIDTH) != 0 || DATA_WIDTH < NIBBLE_WIDTH) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of 4 and at least 4");
  end

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d;
  logic [DATA_WIDTH-1:0]   b_q, b_d;
  logic [DATA_WIDTH-1:0]   res_q, res_d;
  logic [DATA_WIDTH-1:0]   out_res_q, out_res_d;
  logic                    cry_q, cry_d;
  logic                    a_msb_q, a_msb_d;
  logic                    b_msb_q, b_msb_d;
  logic                    brw_q, brw_d;
  logic                    ovf_q, ovf_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [3:0]              w_sum;
  logic                    w_cry;
  logic [DATA_WIDTH-1:0]   w_res_shift;

  adder_04bit_ahead u_nib_add (
    .i_num_a (a_q[3:0]),
    .i_num_b (b_q[3:0]),
    .i_cry   (cry_q),
    .o_sum   (w_sum),
    .o_cry   (w_cry)
  );

  // New sum nibble enters the result register from the top.
  if (DATA_WIDTH == NIBBLE_WIDTH) begin : g_res_single
    assign w_res_shift = w_sum;
  end else begin : g_res_multi
    assign w_res_shift = {w_sum, res_q[DATA_WIDTH-1:NIBBLE_WIDTH]};
  end

  // Next-state and datapath updates for the IDLE/CALC/DONE sequence.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    out_res_d = out_res_q;
    cry_d     = cry_q;
    a_msb_d   = a_msb_q;
    b_msb_d   = b_msb_q;
    brw_d     = brw_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          a_d     = i_num_a;
          b_d     = ~i_num_b;
          cry_d   = ~i_brw;
          a_msb_d = i_num_a[DATA_WIDTH-1];
          b_msb_d = i_num_b[DATA_WIDTH-1];
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        res_d = w_res_shift;
        a_d   = a_q >> NIBBLE_WIDTH;
        b_d   = b_q >> NIBBLE_WIDTH;
        cry_d = w_cry;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == C_LAST) begin
          out_res_d = w_res_shift;
          brw_d     = ~w_cry;
          // Overflow only possible when operand signs differ.
          ovf_d     = (a_msb_q != b_msb_q) && (w_res_shift[DATA_WIDTH-1] != a_msb_q);
          state_d   = DONE;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      out_res_q <= '0;
      cry_q     <= 1'b0;
      a_msb_q   <= 1'b0;
      b_msb_q   <= 1'b0;
      brw_q     <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      out_res_q <= out_res_d;
      cry_q     <= cry_d;
      a_msb_q   <= a_msb_d;
      b_msb_q   <= b_msb_d;
      brw_q     <= brw_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);
  assign o_res   = out_res_q;
  assign o_brw   = brw_q;
  assign o_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_subtractor_nnbit_ahead_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : tb_subtractor_nnbit_ahead_multicycle
// Description : Directed self-checking bench, 8-bit and 16-bit instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_subtractor_nnbit_ahead_multicycle;

  logic clk;
  logic rst_n;

  logic        v8, rdy8, ovld8, ir8, brw8, obrw8, oovf8;
  logic [7:0]  a8, b8, res8;
  logic        v16, rdy16, ovld16, ir16, brw16, obrw16, oovf16;
  logic [15:0] a16, b16, res16;

  int checks;
  int errors;

  subtractor_nnbit_ahead_multicycle #(.DATA_WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v8), .o_ready(rdy8),
    .i_num_a(a8), .i_num_b(b8), .i_brw(brw8), .o_valid(ovld8),
    .i_ready(ir8), .o_res(res8), .o_brw(obrw8), .o_ovf(oovf8)
  );

  subtractor_nnbit_ahead_multicycle #(.DATA_WIDTH(16)) dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v16), .o_ready(rdy16),
    .i_num_a(a16), .i_num_b(b16), .i_brw(brw16), .o_valid(ovld16),
    .i_ready(ir16), .o_res(res16), .o_brw(obrw16), .o_ovf(oovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one 8-bit operation and wait for the result (left in DONE).
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic brw, input logic [7:0] er, input logic eb, input logic eo);
    int lat;
    @(negedge clk);
    chk({tag, "_ready"}, {31'd0, rdy8}, 32'd1);
    a8 = a; b8 = b; brw8 = brw; v8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0;
    lat = 0;
    while (!ovld8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, 32'd2);
    chk({tag, "_res"}, {24'd0, res8}, {24'd0, er});
    chk({tag, "_brw"}, {31'd0, obrw8}, {31'd0, eb});
    chk({tag, "_ovf"}, {31'd0, oovf8}, {31'd0, eo});
  endtask

  task automatic release8(input string tag);
    @(negedge clk);
    v8 = 1'b0; ir8 = 1'b1;
    @(posedge clk); #1;
    ir8 = 1'b0;
    chk({tag, "_idle_ready"}, {31'd0, rdy8}, 32'd1);
    chk({tag, "_idle_valid"}, {31'd0, ovld8}, 32'd0);
  endtask

  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic brw, input logic [15:0] er, input logic eb, input logic eo);
    int lat;
    @(negedge clk);
    chk({tag, "_ready"}, {31'd0, rdy16}, 32'd1);
    a16 = a; b16 = b; brw16 = brw; v16 = 1'b1;
    @(posedge clk); #1;
    v16 = 1'b0;
    lat = 0;
    while (!ovld16 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, 32'd4);
    chk({tag, "_res"}, {16'd0, res16}, {16'd0, er});
    chk({tag, "_brw"}, {31'd0, obrw16}, {31'd0, eb});
    chk({tag, "_ovf"}, {31'd0, oovf16}, {31'd0, eo});
    @(negedge clk);
    ir16 = 1'b1;
    @(posedge clk); #1;
    ir16 = 1'b0;
    chk({tag, "_idle_ready"}, {31'd0, rdy16}, 32'd1);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    v8 = 0; ir8 = 0; a8 = 0; b8 = 0; brw8 = 0;
    v16 = 0; ir16 = 0; a16 = 0; b16 = 0; brw16 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, ovld8}, 32'd0);
    chk("rst_ready", {31'd0, rdy8}, 32'd1);
    chk("rst_res", {24'd0, res8}, 32'd0);
    chk("rst_brw", {31'd0, obrw8}, 32'd0);
    chk("rst_ovf", {31'd0, oovf8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 0x35 - 0x12 = 0x23, then hold in DONE under backpressure.
    run8("sub35_12", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      v8 = ~v8; a8 = 8'($urandom); b8 = 8'($urandom); brw8 = ~brw8;
      @(posedge clk); #1;
      chk("bp_valid", {31'd0, ovld8}, 32'd1);
      chk("bp_ready", {31'd0, rdy8}, 32'd0);
      chk("bp_res", {24'd0, res8}, 32'h23);
      chk("bp_brw", {31'd0, obrw8}, 32'd0);
      chk("bp_ovf", {31'd0, oovf8}, 32'd0);
    end
    release8("bp");
    repeat (2) @(posedge clk);
    #1;
    chk("bp_no_capture", {31'd0, rdy8}, 32'd1);

    run8("sub00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    release8("sub00_01");
    run8("sub80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    release8("sub80_01");
    run8("sub10_0F_b", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
    release8("sub10_0F_b");
    run8("eq_brw", 8'h5A, 8'h5A, 1'b1, 8'hFF, 1'b1, 1'b0);
    release8("eq_brw");

    run16("w16_1234_4321", 16'h1234, 16'h4321, 1'b0, 16'hCF13, 1'b1, 1'b0);
    run16("w16_8000_0001", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);

    // Abort mid-CALC with asynchronous reset.
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h01; brw8 = 1'b0; v8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0;
    chk("abort_in_calc", {31'd0, rdy8}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", {31'd0, ovld8}, 32'd0);
    chk("abort_res", {24'd0, res8}, 32'd0);
    chk("abort_brw", {31'd0, obrw8}, 32'd0);
    chk("abort_ovf", {31'd0, oovf8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("abort_no_valid", {31'd0, ovld8}, 32'd0);
    end
    run8("post_abort", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0);
    release8("post_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
